// File: rtl/aux_perf_counter_bank_pkg.sv
// Shared auxiliary constants for the performance counter bank.
// Covers readout-source encodings, counter mode encodings and the channel limit.
package aux_perf_counter_bank_pkg;

  localparam logic RD_LIVE   = 1'b0;
  localparam logic RD_SHADOW = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int MAX_CH = 16;

endpackage

// File: rtl/aux_perf_counter_ch.sv
// One counter channel: live event counter, snapshot shadow and sticky overflow flag.
module aux_perf_counter_ch
  import aux_perf_counter_bank_pkg::*;
#(
  parameter int CntBit   = 32,
  parameter int Saturate = MODE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic              snap,
  output logic [CntBit-1:0] live,
  output logic [CntBit-1:0] shadow,
  output logic              ovf
);

  localparam logic [CntBit-1:0] CntMax = '1;

  // Shadow samples the pre-edge live value, so snap sees neither this edge's
  // increment nor this edge's clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) begin
        shadow <= live;
      end
      if (clr) begin
        live <= '0;
        ovf  <= 1'b0;
      end else if (inc) begin
        if (live == CntMax) begin
          ovf  <= 1'b1;
          live <= (Saturate == MODE_SAT) ? CntMax : '0;
        end else begin
          live <= live + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aux_perf_counter_bank.sv
// Bank of independent event counters with snapshot shadows and a registered
// readout port selecting one channel from either the live or shadow bank.
module aux_perf_counter_bank
  import aux_perf_counter_bank_pkg::*;
#(
  parameter int NumCh    = 4,
  parameter int CntBit   = 32,
  parameter int Saturate = MODE_WRAP,
  parameter int SelBit   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NumCh-1:0]  ev,
  input  logic              clr,
  input  logic              snap,
  input  logic [SelBit-1:0] sel,
  input  logic              rd_shadow,
  output logic [CntBit-1:0] rd_data,
  output logic [NumCh-1:0]  ovf
);

  logic [CntBit-1:0] live_q   [NumCh];
  logic [CntBit-1:0] shadow_q [NumCh];
  logic [CntBit-1:0] rd_next;

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    aux_perf_counter_ch #(
      .CntBit   (CntBit),
      .Saturate (Saturate)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .inc    (en & ev[i]),
      .clr    (clr),
      .snap   (snap),
      .live   (live_q[i]),
      .shadow (shadow_q[i]),
      .ovf    (ovf[i])
    );
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sel == SelBit'(i)) begin
        rd_next = (rd_shadow == RD_SHADOW) ? shadow_q[i] : live_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule
